id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection. Sits directly downstream of the decode control unit.
//  Captures decoded control bits, operands and register specifiers every cycle for the EX stage.
//  Detects a lw-followed-by-dependent-use pair, asserts stall_o to freeze PC and IF/ID, and inserts one bubble.
// PARAMETERS
//  DATA_W  32  register/immediate datapath width
//  PC_W    32  program-counter width
//  RA_W    5   register-specifier width
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous reset, active-low
//  id_valid_i   in   1       ID holds a real instruction
//  id_regDst_i, id_jump_i, id_branch_i, id_memRead_i, id_memToReg_i  in  1 each  decoded control
//  id_regWrite_i, id_ALUSrc_i, id_memWrite_i                         in  1 each  decoded control
//  id_ALUop_i   in   3       decoded ALU operation
//  id_pc4_i     in   PC_W    PC+4 of ID instruction
//  id_rdata1_i  in   DATA_W  register-file read port 1 (rs)
//  id_rdata2_i  in   DATA_W  register-file read port 2 (rt)
//  id_imm_i     in   DATA_W  sign-extended immediate
//  id_rs_i, id_rt_i, id_rd_i  in  RA_W  register specifiers
//  flush_i      in   1       branch/jump redirect; kill ID instruction
//  hold_i       in   1       downstream stall; freeze this register
//  ex_*_o       out  (same widths as id_*_i)  registered copies for EX, incl. ex_valid_o
//  stall_o      out  1       load-use stall request to PC/IF-ID (combinational)
// BEHAVIOUR
//  Reset (async, rst_n=0): every ex_*_o = 0, including ex_valid_o and ex_ALUop_o=3'b000.
//  stall_o is 0 while in reset.
//  stall_o = ex_valid_o & ex_memRead_o & (ex_rt_o != 0) & id_valid_i &
//            ((ex_rt_o == id_rs_i) | ((ex_rt_o == id_rt_i) & ~id_ALUSrc_i));
//   sw is an exception: it always checks rt, whatever ALUSrc is.
//  Per-edge priority, highest first:
//   1 flush_i: load bubble (valid and all control bits = 0; data/specifier fields don't-care, loaded as 0).
//   2 hold_i: keep all ex_*_o unchanged. stall_o is still driven from the held contents.
//   3 stall_o: load bubble. ID is not consumed, so the same instruction re-presents next cycle.
//   4 otherwise: capture all id_* fields. Latency is exactly 1 cycle ID->EX.
//  Capture sanitising:
//   - If id_valid_i=0, load a bubble.
//   - If id_jump_i=1, regDst, ALUSrc and ALUop load as 0, so no X reaches EX from jump decodes.
//  Bubble invariant: regWrite=memWrite=memRead=branch=jump=0. A bubble never writes architectural state.
//  Load-use stall lasts exactly one cycle (with hold_i=0). The next cycle the bubble sits in EX and stall_o drops.
//  Back-to-back loads: each dependent consumer gets its own single bubble.
//  Reset mid-stall: the register clears and stall_o drops asynchronously.
//  rt = $0 never stalls.
// STRUCTURE
//  Shared package mips_pkg:
//   - ALUop encodings: AND=000, OR=001, ADD=010, LUI=011, SUB=110, SLT=111
//   - BUBBLE control constant
//   - RA_W / DATA_W defaults
//  One sub-module: load_use_detect (purely combinational stall_o equation), instantiated once.
//  Register bank: a single always block sensitive to posedge clk / negedge rst_n.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with random id_* -> all ex_*_o=0, stall_o=0. Release -> capture resumes next edge.
//  2 Pass-through: add $3,$1,$2 (regWrite=1, regDst=1, ALUop=010) -> ex_* match one edge later, stall_o=0.
//  3 Load-use: lw $5,0($1) in EX, add $6,$5,$2 in ID ->
//    stall_o=1 for 1 cycle, EX gets a bubble, add captured on the following edge.
//  4 Flush priority: flush_i=1 together with a load-use condition and a valid sw in ID ->
//    EX gets a bubble, ex_memWrite_o=0.
//  5 Hold: hold_i=1 for 3 cycles with changing id_* -> ex_* stay constant. Release -> newest id_* captured.
//  6 $0 and jump: lw $0 followed by a use of $0 -> no stall.
//    j with X on regDst/ALUop -> ex_regDst_o=0, ex_ALUop_o=000, ex_jump_o=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   - ALU operation encodings produced by the decode control unit
//   - ctrl_t: the decoded control bundle carried from ID to EX
//   - BUBBLE: the control value of an inserted no-op
//   - default datapath widths
//   - sanitise_ctrl(): clears the fields a jump decode leaves undefined
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 32;
  localparam int RA_W_DEF   = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] alu_op;
  } ctrl_t;

  // A bubble writes no architectural state: every enable is zero.
  localparam ctrl_t BUBBLE = '0;

  // Jump decodes leave reg_dst/alu_src/alu_op undefined; force them to 0
  // so nothing unknown reaches EX.
  function automatic ctrl_t sanitise_ctrl(input ctrl_t c);
    ctrl_t r;
    r = c;
    if (c.jump) begin
      r.reg_dst = 1'b0;
      r.alu_src = 1'b0;
      r.alu_op  = ALU_AND;
    end
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rt_i : instruction currently in EX
//   id_valid_i, id_rs_i, id_rt_i       : instruction currently in ID
//   id_alu_src_i, id_mem_write_i       : decide whether ID actually reads rt
//   stall_o                            : 1 when the ID instruction needs the EX load's result
module load_use_detect
  import mips_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            ex_valid_i,
  input  logic            ex_mem_read_i,
  input  logic [RA_W-1:0] ex_rt_i,
  input  logic            id_valid_i,
  input  logic [RA_W-1:0] id_rs_i,
  input  logic [RA_W-1:0] id_rt_i,
  input  logic            id_alu_src_i,
  input  logic            id_mem_write_i,
  output logic            stall_o
);

  logic rt_used;
  logic load_in_ex;

  // rt is a source unless ALUSrc selects the immediate; a store reads rt
  // as its data operand even though ALUSrc is set.
  assign rt_used    = ~id_alu_src_i | id_mem_write_i;
  // $0 is hardwired to zero, so a load targeting it creates no dependency.
  assign load_in_ex = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0);

  assign stall_o = load_in_ex & id_valid_i &
                   ((ex_rt_i == id_rs_i) | ((ex_rt_i == id_rt_i) & rt_used));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_*_i                : decoded instruction, operands and specifiers from ID
//   flush_i               : kill the ID instruction (branch/jump redirect)
//   hold_i                : downstream stall, freeze this register
//   ex_*_o                : registered copies for EX (ex_valid_o marks a real instruction)
//   stall_o               : load-use stall request to PC and IF/ID
// Flow control: the register advances every edge unless hold_i is set.
// When stall_o is high the ID instruction is not consumed; upstream must
// present it again next cycle while a bubble enters EX. flush_i beats
// hold_i, which beats stall_o.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic              id_regDst_i,
  input  logic              id_jump_i,
  input  logic              id_branch_i,
  input  logic              id_memRead_i,
  input  logic              id_memToReg_i,
  input  logic              id_regWrite_i,
  input  logic              id_ALUSrc_i,
  input  logic              id_memWrite_i,
  input  logic [2:0]        id_ALUop_i,
  input  logic [PC_W-1:0]   id_pc4_i,
  input  logic [DATA_W-1:0] id_rdata1_i,
  input  logic [DATA_W-1:0] id_rdata2_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [RA_W-1:0]   id_rs_i,
  input  logic [RA_W-1:0]   id_rt_i,
  input  logic [RA_W-1:0]   id_rd_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_valid_o,
  output logic              ex_regDst_o,
  output logic              ex_jump_o,
  output logic              ex_branch_o,
  output logic              ex_memRead_o,
  output logic              ex_memToReg_o,
  output logic              ex_regWrite_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_memWrite_o,
  output logic [2:0]        ex_ALUop_o,
  output logic [PC_W-1:0]   ex_pc4_o,
  output logic [DATA_W-1:0] ex_rdata1_o,
  output logic [DATA_W-1:0] ex_rdata2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [RA_W-1:0]   ex_rs_o,
  output logic [RA_W-1:0]   ex_rt_o,
  output logic [RA_W-1:0]   ex_rd_o,
  output logic              stall_o
);

  ctrl_t             id_ctrl;
  ctrl_t             ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [PC_W-1:0]   pc4_d, pc4_q;
  logic [DATA_W-1:0] rdata1_d, rdata1_q;
  logic [DATA_W-1:0] rdata2_d, rdata2_q;
  logic [DATA_W-1:0] imm_d, imm_q;
  logic [RA_W-1:0]   rs_d, rs_q;
  logic [RA_W-1:0]   rt_d, rt_q;
  logic [RA_W-1:0]   rd_d, rd_q;
  logic              stall;

  assign id_ctrl = '{reg_dst:    id_regDst_i,
                     jump:       id_jump_i,
                     branch:     id_branch_i,
                     mem_read:   id_memRead_i,
                     mem_to_reg: id_memToReg_i,
                     reg_write:  id_regWrite_i,
                     alu_src:    id_ALUSrc_i,
                     mem_write:  id_memWrite_i,
                     alu_op:     id_ALUop_i};

  // Detection looks at the registered EX contents, so a held register
  // keeps driving the same stall decision.
  load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q.mem_read),
    .ex_rt_i        (rt_q),
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_alu_src_i   (id_ALUSrc_i),
    .id_mem_write_i (id_memWrite_i),
    .stall_o        (stall)
  );

  always_comb begin
    // Default: keep contents (the hold case).
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    pc4_d    = pc4_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    if (flush_i || (!hold_i && (stall || !id_valid_i))) begin
      valid_d  = 1'b0;
      ctrl_d   = BUBBLE;
      pc4_d    = '0;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
    end else if (!hold_i) begin
      valid_d  = 1'b1;
      ctrl_d   = sanitise_ctrl(id_ctrl);
      pc4_d    = id_pc4_i;
      rdata1_d = id_rdata1_i;
      rdata2_d = id_rdata2_i;
      imm_d    = id_imm_i;
      rs_d     = id_rs_i;
      rt_d     = id_rt_i;
      rd_d     = id_rd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= BUBBLE;
      pc4_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      pc4_q    <= pc4_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_regDst_o   = ctrl_q.reg_dst;
  assign ex_jump_o     = ctrl_q.jump;
  assign ex_branch_o   = ctrl_q.branch;
  assign ex_memRead_o  = ctrl_q.mem_read;
  assign ex_memToReg_o = ctrl_q.mem_to_reg;
  assign ex_regWrite_o = ctrl_q.reg_write;
  assign ex_ALUSrc_o   = ctrl_q.alu_src;
  assign ex_memWrite_o = ctrl_q.mem_write;
  assign ex_ALUop_o    = ctrl_q.alu_op;
  assign ex_pc4_o      = pc4_q;
  assign ex_rdata1_o   = rdata1_q;
  assign ex_rdata2_o   = rdata2_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs_o       = rs_q;
  assign ex_rt_o       = rt_q;
  assign ex_rd_o       = rd_q;
  assign stall_o       = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle vector table plus
// hand-written reset sequences.
module tb_id_ex_stage;

  // control packing: {regDst, jump, branch, memRead, memToReg, regWrite, ALUSrc, memWrite, ALUop[2:0]}
  localparam logic [10:0] C_ADD  = {8'b1000_0100, 3'b010};
  localparam logic [10:0] C_ADDI = {8'b0000_0110, 3'b010};
  localparam logic [10:0] C_LW   = {8'b0001_1110, 3'b010};
  localparam logic [10:0] C_SW   = {8'b0000_0011, 3'b010};
  localparam logic [10:0] C_J_IN = {8'b1100_0010, 3'b111};
  localparam logic [10:0] C_J    = {8'b0100_0000, 3'b000};
  localparam logic [10:0] C_BUB  = 11'd0;

  localparam int K_BUB  = 0;
  localparam int K_CAP  = 1;
  localparam int K_HOLD = 2;
  localparam int NROWS  = 26;

  typedef struct {
    logic        valid;
    logic        flush;
    logic        hold;
    logic [10:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        exp_stall;
    int          kind;
    logic [10:0] exp_ctrl;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        id_valid_i, id_regDst_i, id_jump_i, id_branch_i, id_memRead_i;
  logic        id_memToReg_i, id_regWrite_i, id_ALUSrc_i, id_memWrite_i;
  logic [2:0]  id_ALUop_i;
  logic [31:0] id_pc4_i, id_rdata1_i, id_rdata2_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        flush_i, hold_i;
  logic        ex_valid_o, ex_regDst_o, ex_jump_o, ex_branch_o, ex_memRead_o;
  logic        ex_memToReg_o, ex_regWrite_o, ex_ALUSrc_o, ex_memWrite_o;
  logic [2:0]  ex_ALUop_o;
  logic [31:0] ex_pc4_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic        stall_o;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_regDst_i(id_regDst_i), .id_jump_i(id_jump_i),
    .id_branch_i(id_branch_i), .id_memRead_i(id_memRead_i), .id_memToReg_i(id_memToReg_i),
    .id_regWrite_i(id_regWrite_i), .id_ALUSrc_i(id_ALUSrc_i), .id_memWrite_i(id_memWrite_i),
    .id_ALUop_i(id_ALUop_i), .id_pc4_i(id_pc4_i), .id_rdata1_i(id_rdata1_i),
    .id_rdata2_i(id_rdata2_i), .id_imm_i(id_imm_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rd_i(id_rd_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid_o(ex_valid_o), .ex_regDst_o(ex_regDst_o), .ex_jump_o(ex_jump_o),
    .ex_branch_o(ex_branch_o), .ex_memRead_o(ex_memRead_o), .ex_memToReg_o(ex_memToReg_o),
    .ex_regWrite_o(ex_regWrite_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_memWrite_o(ex_memWrite_o),
    .ex_ALUop_o(ex_ALUop_o), .ex_pc4_o(ex_pc4_o), .ex_rdata1_o(ex_rdata1_o),
    .ex_rdata2_o(ex_rdata2_o), .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
    .ex_rd_o(ex_rd_o), .stall_o(stall_o)
  );

  int checks = 0;
  int errors = 0;
  vec_t tbl[NROWS];

  // expected EX contents
  logic        e_valid;
  logic [10:0] e_ctrl;
  logic [31:0] e_pc4, e_r1, e_r2, e_imm;
  logic [4:0]  e_rs, e_rt, e_rd;

  function automatic vec_t mk(logic v, logic f, logic h, logic [10:0] c,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic es, int k, logic [10:0] ec);
    vec_t r;
    r.valid = v; r.flush = f; r.hold = h; r.ctrl = c;
    r.rs = rs; r.rt = rt; r.rd = rd;
    r.exp_stall = es; r.kind = k; r.exp_ctrl = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [10:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] tag);
    id_valid_i = v;
    {id_regDst_i, id_jump_i, id_branch_i, id_memRead_i, id_memToReg_i,
     id_regWrite_i, id_ALUSrc_i, id_memWrite_i, id_ALUop_i} = c;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_pc4_i    = 32'h0000_0400 + (tag << 2);
    id_rdata1_i = 32'hA100_0000 | tag;
    id_rdata2_i = 32'hB200_0000 | tag;
    id_imm_i    = 32'hC300_0000 | tag;
  endtask

  task automatic chk_ex(input string p);
    chk({p, "_valid"}, 32'(ex_valid_o), 32'(e_valid));
    chk({p, "_ctrl"}, 32'({ex_regDst_o, ex_jump_o, ex_branch_o, ex_memRead_o, ex_memToReg_o,
                           ex_regWrite_o, ex_ALUSrc_o, ex_memWrite_o, ex_ALUop_o}), 32'(e_ctrl));
    chk({p, "_pc4"}, ex_pc4_o, e_pc4);
    chk({p, "_rdata1"}, ex_rdata1_o, e_r1);
    chk({p, "_rdata2"}, ex_rdata2_o, e_r2);
    chk({p, "_imm"}, ex_imm_o, e_imm);
    chk({p, "_rs"}, 32'(ex_rs_o), 32'(e_rs));
    chk({p, "_rt"}, 32'(ex_rt_o), 32'(e_rt));
    chk({p, "_rd"}, 32'(ex_rd_o), 32'(e_rd));
  endtask

  task automatic set_bubble();
    e_valid = 1'b0; e_ctrl = C_BUB; e_pc4 = '0; e_r1 = '0; e_r2 = '0; e_imm = '0;
    e_rs = '0; e_rt = '0; e_rd = '0;
  endtask

  task automatic set_capture(input logic [10:0] c);
    e_valid = 1'b1; e_ctrl = c; e_pc4 = id_pc4_i; e_r1 = id_rdata1_i; e_r2 = id_rdata2_i;
    e_imm = id_imm_i; e_rs = id_rs_i; e_rt = id_rt_i; e_rd = id_rd_i;
  endtask

  task automatic run_row(input int i);
    vec_t v;
    v = tbl[i];
    @(negedge clk);
    drive(v.valid, v.ctrl, v.rs, v.rt, v.rd, 32'(i));
    flush_i = v.flush;
    hold_i  = v.hold;
    #1;
    chk($sformatf("row%0d_stall", i), 32'(stall_o), 32'(v.exp_stall));
    @(posedge clk);
    #1;
    if (v.kind == K_BUB) set_bubble();
    else if (v.kind == K_CAP) set_capture(v.exp_ctrl);
    chk_ex($sformatf("row%0d", i));
  endtask

  initial begin
    // rows: valid flush hold ctrl rs rt rd | stall-before-edge kind expected-ctrl
    tbl[0]  = mk(1, 0, 0, C_ADD,  1,  2,  3, 0, K_CAP,  C_ADD);  // add $3,$1,$2
    tbl[1]  = mk(1, 0, 0, C_LW,   1,  5,  0, 0, K_CAP,  C_LW);   // lw $5,0($1)
    tbl[2]  = mk(1, 0, 0, C_ADD,  5,  2,  6, 1, K_BUB,  C_BUB);  // add $6,$5,$2 stalls
    tbl[3]  = mk(1, 0, 0, C_ADD,  5,  2,  6, 0, K_CAP,  C_ADD);  // re-presented
    tbl[4]  = mk(1, 0, 0, C_LW,   1,  7,  0, 0, K_CAP,  C_LW);   // lw $7
    tbl[5]  = mk(1, 0, 0, C_LW,   7,  8,  0, 1, K_BUB,  C_BUB);  // lw $8,0($7)
    tbl[6]  = mk(1, 0, 0, C_LW,   7,  8,  0, 0, K_CAP,  C_LW);
    tbl[7]  = mk(1, 0, 0, C_ADD,  2,  8,  9, 1, K_BUB,  C_BUB);  // add $9,$2,$8 (rt dep)
    tbl[8]  = mk(1, 0, 0, C_ADD,  2,  8,  9, 0, K_CAP,  C_ADD);
    tbl[9]  = mk(1, 0, 0, C_LW,   1, 10,  0, 0, K_CAP,  C_LW);   // lw $10
    tbl[10] = mk(1, 0, 0, C_ADDI, 2, 10,  0, 0, K_CAP,  C_ADDI); // addi $10: rt is dest
    tbl[11] = mk(1, 0, 0, C_LW,   1, 12,  0, 0, K_CAP,  C_LW);   // lw $12
    tbl[12] = mk(1, 0, 0, C_SW,   2, 12,  0, 1, K_BUB,  C_BUB);  // sw $12 reads rt
    tbl[13] = mk(1, 0, 0, C_SW,   2, 12,  0, 0, K_CAP,  C_SW);
    tbl[14] = mk(1, 0, 0, C_LW,   1, 13,  0, 0, K_CAP,  C_LW);   // lw $13
    tbl[15] = mk(1, 1, 0, C_SW,   2, 13,  0, 1, K_BUB,  C_BUB);  // flush beats stall
    tbl[16] = mk(1, 0, 0, C_ADD,  1,  2, 14, 0, K_CAP,  C_ADD);
    tbl[17] = mk(1, 0, 0, C_LW,   1,  0,  0, 0, K_CAP,  C_LW);   // lw $0
    tbl[18] = mk(1, 0, 0, C_ADD,  0,  0, 15, 0, K_CAP,  C_ADD);  // use $0: no stall
    tbl[19] = mk(1, 0, 0, C_J_IN, 3,  4,  5, 0, K_CAP,  C_J);    // j with junk fields
    tbl[20] = mk(0, 0, 0, C_ADD,  1,  2,  3, 0, K_BUB,  C_BUB);  // invalid ID
    tbl[21] = mk(1, 0, 0, C_LW,   1, 16,  0, 0, K_CAP,  C_LW);   // lw $16
    tbl[22] = mk(1, 0, 1, C_ADD, 16,  2, 17, 1, K_HOLD, C_BUB);  // hold, stall still seen
    tbl[23] = mk(1, 0, 1, C_ADD, 16,  3, 18, 1, K_HOLD, C_BUB);
    tbl[24] = mk(1, 0, 1, C_ADD,  5,  6, 19, 0, K_HOLD, C_BUB);
    tbl[25] = mk(1, 0, 0, C_ADD,  1,  2, 20, 0, K_CAP,  C_ADD);  // release: newest captured

    // reset with random ID contents
    flush_i = 1'b0;
    hold_i  = 1'b0;
    drive(1'b1, 11'($urandom_range(0, 2047)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 32'($urandom));
    repeat (2) @(posedge clk);
    drive(1'b1, C_LW, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)),
          5'($urandom_range(0, 31)), 32'($urandom));
    #1;
    set_bubble();
    chk_ex("reset");
    chk("reset_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NROWS; i++) run_row(i);

    // reset in the middle of a load-use stall
    @(negedge clk);
    drive(1'b1, C_LW, 5'd1, 5'd21, 5'd0, 32'd100);
    @(posedge clk);
    #1;
    @(negedge clk);
    drive(1'b1, C_ADD, 5'd21, 5'd2, 5'd22, 32'd101);
    #1;
    chk("mid_stall_pre", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    set_bubble();
    chk("mid_stall_drop", 32'(stall_o), 32'd0);
    chk_ex("mid_reset");
    @(posedge clk);
    #1;
    chk_ex("mid_reset_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    set_capture(C_ADD);
    chk_ex("post_reset_cap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
